// File: rtl/xor_state_tracker.sv
// xor_state_tracker
//   Spin-state register for the annealer. The current state is updated by
//   XOR flip masks accepted through a valid/ready handshake. A signed energy
//   accumulator adds each flip's delta. A snapshot of the lowest-energy
//   state seen so far is kept for the readout path.
//
//   Optional build macro: FLIP_COUNT_EN
//     When defined, a saturating counter of accepted nonzero-mask flips is
//     built. When undefined, flip_count is tied to 0.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   freeze          holds every register and forces flip_ready low
//   load_valid      strobe that starts a new run from load_state/load_energy
//   load_state      initial state captured on load
//   load_energy     initial energy captured on load
//   flip_valid      flip request valid
//   flip_ready      flip request accepted when flip_valid && flip_ready
//   flip_mask       state bits to toggle
//   flip_delta      signed energy change of the flip
//   state_q         current state
//   energy_q        current energy
//   best_state_q    lowest-energy state captured
//   best_energy_q   energy of best_state_q
//   best_update     pulse in the cycle after a best capture
//   flip_count      accepted nonzero-mask flip count (0 without FLIP_COUNT_EN)
module xor_state_tracker #(
  parameter int WIDTH    = 1024,
  parameter int ENERGY_W = 32,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                freeze,
  input  logic                load_valid,
  input  logic [WIDTH-1:0]    load_state,
  input  logic [ENERGY_W-1:0] load_energy,
  input  logic                flip_valid,
  output logic                flip_ready,
  input  logic [WIDTH-1:0]    flip_mask,
  input  logic [ENERGY_W-1:0] flip_delta,
  output logic [WIDTH-1:0]    state_q,
  output logic [ENERGY_W-1:0] energy_q,
  output logic [WIDTH-1:0]    best_state_q,
  output logic [ENERGY_W-1:0] best_energy_q,
  output logic                best_update,
  output logic [CNT_W-1:0]    flip_count
);

  logic [WIDTH-1:0]    state_d;
  logic [ENERGY_W-1:0] energy_d;
  logic [WIDTH-1:0]    best_state_d;
  logic [ENERGY_W-1:0] best_energy_d;
  logic                best_update_q;
  logic                best_update_d;
  logic                flip_acc;
  logic                best_better;

  assign flip_ready  = !freeze && !load_valid;
  assign flip_acc    = flip_valid && flip_ready;
  // Compare on registered values: the snapshot trails the state by a cycle.
  assign best_better = $signed(energy_q) < $signed(best_energy_q);

  always_comb begin
    state_d       = state_q;
    energy_d      = energy_q;
    best_state_d  = best_state_q;
    best_energy_d = best_energy_q;
    best_update_d = 1'b0;
    if (freeze) begin
      // Everything holds; a pending compare simply re-evaluates once
      // freeze drops, since its inputs have not moved.
      best_update_d = 1'b0;
    end else if (load_valid) begin
      state_d       = load_state;
      energy_d      = load_energy;
      best_state_d  = load_state;
      best_energy_d = load_energy;
    end else begin
      if (flip_acc) begin
        state_d  = state_q ^ flip_mask;
        energy_d = energy_q + flip_delta;
      end
      // Independent of the flip: captures the pre-edge state/energy.
      if (best_better) begin
        best_state_d  = state_q;
        best_energy_d = energy_q;
        best_update_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= '0;
      energy_q      <= '0;
      best_state_q  <= '0;
      best_energy_q <= '0;
      best_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      energy_q      <= energy_d;
      best_state_q  <= best_state_d;
      best_energy_q <= best_energy_d;
      best_update_q <= best_update_d;
    end
  end

  assign best_update = best_update_q;

`ifdef FLIP_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] flip_count_q;
  logic [CNT_W-1:0] flip_count_d;

  always_comb begin
    flip_count_d = flip_count_q;
    if (freeze) begin
      flip_count_d = flip_count_q;
    end else if (load_valid) begin
      flip_count_d = '0;
    end else if (flip_acc && (|flip_mask) && (flip_count_q != '1)) begin
      flip_count_d = flip_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_count_q <= '0;
    end else begin
      flip_count_q <= flip_count_d;
    end
  end

  assign flip_count = flip_count_q;
`else
  assign flip_count = '0;
`endif

endmodule

// File: tb/tb_xor_state_tracker.sv
module tb_xor_state_tracker;

  localparam int WIDTH    = 8;
  localparam int ENERGY_W = 16;
  localparam int CNT_W    = 2;

  logic                clk;
  logic                rst_n;
  logic                freeze;
  logic                load_valid;
  logic [WIDTH-1:0]    load_state;
  logic [ENERGY_W-1:0] load_energy;
  logic                flip_valid;
  logic                flip_ready;
  logic [WIDTH-1:0]    flip_mask;
  logic [ENERGY_W-1:0] flip_delta;
  logic [WIDTH-1:0]    state_q;
  logic [ENERGY_W-1:0] energy_q;
  logic [WIDTH-1:0]    best_state_q;
  logic [ENERGY_W-1:0] best_energy_q;
  logic                best_update;
  logic [CNT_W-1:0]    flip_count;

  xor_state_tracker #(
    .WIDTH(WIDTH), .ENERGY_W(ENERGY_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .load_valid(load_valid), .load_state(load_state), .load_energy(load_energy),
    .flip_valid(flip_valid), .flip_ready(flip_ready),
    .flip_mask(flip_mask), .flip_delta(flip_delta),
    .state_q(state_q), .energy_q(energy_q),
    .best_state_q(best_state_q), .best_energy_q(best_energy_q),
    .best_update(best_update), .flip_count(flip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              tag;
    bit                 rdy;
    logic [WIDTH-1:0]   st;
    logic [ENERGY_W-1:0] en;
    logic [WIDTH-1:0]   bst;
    logic [ENERGY_W-1:0] ben;
    bit                 bu;
    logic [CNT_W-1:0]   fc;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic logic [CNT_W-1:0] exp_fc(input int v);
`ifdef FLIP_COUNT_EN
    return CNT_W'(v);
`else
    return CNT_W'(v * 0);
`endif
  endfunction

  function automatic void chk(input string tag, input string fld,
                              input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s.%s: got %h, expected %h", tag, fld, act, req);
    end
  endfunction

  // Monitor: outputs are presented once per cycle; each queued expectation
  // is matched against the DUT half a cycle after its edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, "flip_ready",    32'(flip_ready),    32'(e.rdy));
      chk(e.tag, "state_q",       32'(state_q),       32'(e.st));
      chk(e.tag, "energy_q",      32'(energy_q),      32'(e.en));
      chk(e.tag, "best_state_q",  32'(best_state_q),  32'(e.bst));
      chk(e.tag, "best_energy_q", 32'(best_energy_q), 32'(e.ben));
      chk(e.tag, "best_update",   32'(best_update),   32'(e.bu));
      chk(e.tag, "flip_count",    32'(flip_count),    32'(e.fc));
    end
  end

  task automatic push(input string tag, input bit rdy, input logic [7:0] st,
                      input int en, input logic [7:0] bst, input int ben,
                      input bit bu, input int fc);
    exp_t e;
    e.tag = tag; e.rdy = rdy; e.st = st; e.en = ENERGY_W'(en);
    e.bst = bst; e.ben = ENERGY_W'(ben); e.bu = bu; e.fc = exp_fc(fc);
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, then queue the outputs expected after the edge.
  task automatic step(input string tag, input bit fz, input bit ld,
                      input logic [7:0] ls, input int le, input bit fv,
                      input logic [7:0] fm, input int fd,
                      input bit e_rdy, input logic [7:0] e_st, input int e_en,
                      input logic [7:0] e_bst, input int e_ben,
                      input bit e_bu, input int e_fc);
    @(negedge clk);
    #1;
    freeze      = fz;
    load_valid  = ld;
    load_state  = ls;
    load_energy = ENERGY_W'(le);
    flip_valid  = fv;
    flip_mask   = fm;
    flip_delta  = ENERGY_W'(fd);
    @(posedge clk);
    push(tag, e_rdy, e_st, e_en, e_bst, e_ben, e_bu, e_fc);
  endtask

  initial begin
    rst_n = 1'b0;
    freeze = 1'b0; load_valid = 1'b0; load_state = '0; load_energy = '0;
    flip_valid = 1'b0; flip_mask = '0; flip_delta = '0;

    //      tag           fz ld ls     le      fv fm     fd    rdy st     en      bst    ben     bu fc
    step("reset",         0, 0, 8'h00, 0,      0, 8'h00, 0,    1, 8'h00, 0,      8'h00, 0,      0, 0);
    @(negedge clk); #1; rst_n = 1'b1;
    step("load",          0, 1, 8'hA5, 10,     0, 8'h00, 0,    0, 8'hA5, 10,     8'hA5, 10,     0, 0);
    step("flip0f",        0, 0, 8'h00, 0,      1, 8'h0F, -3,   1, 8'hAA, 7,      8'hA5, 10,     0, 1);
    step("flipf0",        0, 0, 8'h00, 0,      1, 8'hF0, -2,   1, 8'h5A, 5,      8'hAA, 7,      1, 2);
    step("cap2",          0, 0, 8'h00, 0,      0, 8'h00, 0,    1, 8'h5A, 5,      8'h5A, 5,      1, 2);
    step("settle",        0, 0, 8'h00, 0,      0, 8'h00, 0,    1, 8'h5A, 5,      8'h5A, 5,      0, 2);
    step("zero_mask",     0, 0, 8'h00, 0,      1, 8'h00, 1,    1, 8'h5A, 6,      8'h5A, 5,      0, 2);
    step("up4",           0, 0, 8'h00, 0,      1, 8'h01, 4,    1, 8'h5B, 10,     8'h5A, 5,      0, 3);
    step("down5",         0, 0, 8'h00, 0,      1, 8'h01, -5,   1, 8'h5A, 5,      8'h5A, 5,      0, 3);
    step("equal_a",       0, 0, 8'h00, 0,      0, 8'h00, 0,    1, 8'h5A, 5,      8'h5A, 5,      0, 3);
    step("equal_b",       0, 0, 8'h00, 0,      0, 8'h00, 0,    1, 8'h5A, 5,      8'h5A, 5,      0, 3);
    step("load_vs_flip",  0, 1, 8'h3C, 20,     1, 8'hFF, -100, 0, 8'h3C, 20,     8'h3C, 20,     0, 0);
    step("flip03",        0, 0, 8'h00, 0,      1, 8'h03, -5,   1, 8'h3F, 15,     8'h3C, 20,     0, 1);
    step("freeze_a",      1, 0, 8'h00, 0,      1, 8'hFF, -7,   0, 8'h3F, 15,     8'h3C, 20,     0, 1);
    step("freeze_b",      1, 0, 8'h00, 0,      0, 8'h00, 0,    0, 8'h3F, 15,     8'h3C, 20,     0, 1);
    step("deferred_cap",  0, 0, 8'h00, 0,      0, 8'h00, 0,    1, 8'h3F, 15,     8'h3F, 15,     1, 1);
    step("after_cap",     0, 0, 8'h00, 0,      0, 8'h00, 0,    1, 8'h3F, 15,     8'h3F, 15,     0, 1);
    step("load_max",      0, 1, 8'h81, 32767,  0, 8'h00, 0,    0, 8'h81, 32767,  8'h81, 32767,  0, 0);
    step("wrap",          0, 0, 8'h00, 0,      1, 8'h80, 1,    1, 8'h01, 32768,  8'h81, 32767,  0, 1);
    step("wrap_cap",      0, 0, 8'h00, 0,      0, 8'h00, 0,    1, 8'h01, 32768,  8'h01, 32768,  1, 1);

    // Asynchronous reset asserted between edges while frozen.
    @(negedge clk); #1;
    freeze = 1'b1; load_valid = 1'b0; flip_valid = 1'b1;
    flip_mask = 8'hFF; flip_delta = ENERGY_W'(5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    push("async_rst", 0, 8'h00, 0, 8'h00, 0, 0, 0);
    @(negedge clk); #1; rst_n = 1'b1;
    step("post_rst",      0, 0, 8'h00, 0,      0, 8'h00, 0,    1, 8'h00, 0,      8'h00, 0,      0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
